// File: rtl/dm_sized_if.sv
// Request/response port of the sized data memory: valid/ready request channel
// and a one-cycle response pulse carrying load data and an error flag.
interface dm_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_sized.sv
// Byte-addressed big-endian data memory with byte/halfword/word accesses,
// load sign/zero extension, alignment/range errors and configurable wait states.
module dm_sized #(
    parameter int DATA_MEM_SIZE = 128,
    parameter int WAIT_CYCLES   = 0
) (
    input  logic      clk,
    input  logic      rst,
    dm_sized_if.slave bus
);
    localparam int ADDR_W = $clog2(DATA_MEM_SIZE);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT       state;
    logic [3:0]  waitCnt;
    logic        capWrite;
    logic [31:0] capAddr;
    logic [1:0]  capSize;
    logic        capUnsigned;
    logic [31:0] capWdata;
    logic        respValidQ;
    logic [31:0] respRdataQ;
    logic        respErrQ;

    logic [7:0]  mem [DATA_MEM_SIZE];

    logic        accept;
    logic        commit;
    logic        effWrite;
    logic [31:0] effAddr;
    logic [1:0]  effSize;
    logic        effUnsigned;
    logic [31:0] effWdata;
    logic [32:0] accBytes;
    logic        effErr;
    logic [ADDR_W-1:0] idx0, idx1, idx2, idx3;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] loadData;

    assign bus.req_ready  = (state == IDLE) & ~rst;
    assign bus.resp_valid = respValidQ;
    assign bus.resp_rdata = respRdataQ;
    assign bus.resp_err   = respErrQ;

    assign accept = bus.req_valid & bus.req_ready;

    // With no wait states the commit edge is the acceptance edge, so the live
    // request is used there; otherwise the captured copy is used.
    assign commit = ~rst & (((state == IDLE) & accept & (WAIT_CYCLES == 0)) |
                            ((state == BUSY) & (waitCnt == 4'd0)));

    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        effWrite    = capWrite;
        effAddr     = capAddr;
        effSize     = capSize;
        effUnsigned = capUnsigned;
        effWdata    = capWdata;
        if (state == IDLE) begin
            effWrite    = bus.req_write;
            effAddr     = bus.req_addr;
            effSize     = bus.req_size;
            effUnsigned = bus.req_unsigned;
            effWdata    = bus.req_wdata;
        end
    end

    always_comb begin
        accBytes = 33'd4;
        case (effSize)
            2'b00:   accBytes = 33'd1;
            2'b01:   accBytes = 33'd2;
            default: accBytes = 33'd4;
        endcase
        // 33-bit sum so an address near the top of the space cannot wrap into range.
        effErr = (effSize == 2'b11) |
                 ((effSize == 2'b01) & effAddr[0]) |
                 ((effSize == 2'b10) & (|effAddr[1:0])) |
                 (({1'b0, effAddr} + accBytes) > 33'(DATA_MEM_SIZE));
    end

    always_comb begin
        idx0 = effAddr[ADDR_W-1:0];
        idx1 = idx0 + 1'b1;
        idx2 = idx0 + 2'd2;
        idx3 = idx0 + 2'd3;
        b0   = mem[idx0];
        b1   = mem[idx1];
        b2   = mem[idx2];
        b3   = mem[idx3];
        case (effSize)
            2'b00:   loadData = {{24{~effUnsigned & b0[7]}}, b0};
            2'b01:   loadData = {{16{~effUnsigned & b0[7]}}, b0, b1};
            default: loadData = {b0, b1, b2, b3};
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            respValidQ <= 1'b0;
            respRdataQ <= 32'd0;
            respErrQ   <= 1'b0;
        end else begin
            respValidQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        capWrite    <= bus.req_write;
                        capAddr     <= bus.req_addr;
                        capSize     <= bus.req_size;
                        capUnsigned <= bus.req_unsigned;
                        capWdata    <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state   <= BUSY;
                            waitCnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                BUSY: begin
                    if (waitCnt == 4'd0) state <= RESP;
                    else                 waitCnt <= waitCnt - 4'd1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                respValidQ <= 1'b1;
                respErrQ   <= effErr;
                respRdataQ <= (effErr | effWrite) ? 32'd0 : loadData;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive rst and it maps
    // onto plain RAM rather than a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (commit && effWrite && !effErr) begin
            case (effSize)
                2'b00: mem[idx0] <= effWdata[7:0];
                2'b01: begin
                    mem[idx0] <= effWdata[15:8];
                    mem[idx1] <= effWdata[7:0];
                end
                default: begin
                    mem[idx0] <= effWdata[31:24];
                    mem[idx1] <= effWdata[23:16];
                    mem[idx2] <= effWdata[15:8];
                    mem[idx3] <= effWdata[7:0];
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_sized.sv
// Bench for dm_sized: scoreboarded directed/random traffic on a zero-wait
// instance and cycle-exact timing/reset checks on a three-wait-state instance.
module tb_dm_sized;
    localparam int MEM = 128;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } expT;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst3 = 1'b1;
    int   nChecks = 0;
    int   nPass = 0;
    expT  sbQ[$];
    logic [7:0] sbMem [MEM];
    logic prevValid0 = 1'b0;

    dm_sized_if bus0 ();
    dm_sized_if bus3 ();

    dm_sized #(.DATA_MEM_SIZE(MEM), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    dm_sized #(.DATA_MEM_SIZE(MEM), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: big-endian byte array, computed byte by byte.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                  input logic uns, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err);
        int n;
        int a;
        logic [31:0] v;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00) ||
              (({1'b0, addr} + 33'(n)) > 33'(MEM));
        rd = 32'd0;
        if (!err) begin
            a = int'(addr[7:0]);
            if (wr) begin
                for (int i = 0; i < n; i++) sbMem[a + i] = 8'(wdata >> (8 * (n - 1 - i)));
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(sbMem[a + i]);
                if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
                rd = v;
            end
        end
    endfunction

    task automatic issue0(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
        expT e;
        int budget;
        @(negedge clk);
        budget = 0;
        while (!bus0.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("ready0", 32'(bus0.req_ready), 32'd1);
        bus0.req_write = wr;
        bus0.req_addr = addr;
        bus0.req_size = size;
        bus0.req_unsigned = uns;
        bus0.req_wdata = wdata;
        bus0.req_valid = 1'b1;
        model(wr, addr, size, uns, wdata, e.rdata, e.err);
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'($urandom());
        bus0.req_addr = $urandom();
        bus0.req_size = 2'($urandom());
        bus0.req_wdata = $urandom();
        @(negedge clk);
        check("latency0", 32'(bus0.resp_valid), 32'd1);
        rd = bus0.resp_rdata;
        er = bus0.resp_err;
    endtask

    task automatic issue3(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er);
        int budget;
        @(negedge clk);
        budget = 0;
        while (!bus3.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("ready3", 32'(bus3.req_ready), 32'd1);
        bus3.req_write = wr;
        bus3.req_addr = addr;
        bus3.req_size = size;
        bus3.req_unsigned = uns;
        bus3.req_wdata = wdata;
        bus3.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus3.req_valid = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!bus3.resp_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("resp3_seen", 32'(bus3.resp_valid), 32'd1);
        rd = bus3.resp_rdata;
        er = bus3.resp_err;
    endtask

    // Scoreboard consumer for the zero-wait instance.
    always @(negedge clk) begin
        expT e;
        if (bus0.resp_valid === 1'b1) begin
            check("resp_double", 32'(prevValid0), 32'd0);
            if (sbQ.size() == 0) begin
                check("resp_unexpected", 32'(bus0.resp_valid), 32'd0);
            end else begin
                e = sbQ.pop_front();
                check("sb_rdata", bus0.resp_rdata, e.rdata);
                check("sb_err", 32'(bus0.resp_err), 32'(e.err));
            end
        end
        prevValid0 = (bus0.resp_valid === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] addr;
        logic vHist [1:9];
        logic rHist [1:9];
        logic [31:0] dHist [1:9];
        logic eHist [1:9];
        int seen;
        int budget;

        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0;
        bus0.req_size = '0; bus0.req_unsigned = 1'b0; bus0.req_wdata = '0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0;
        bus3.req_size = '0; bus3.req_unsigned = 1'b0; bus3.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(bus0.req_ready), 32'd0);
        check("rst_valid0", 32'(bus0.resp_valid), 32'd0);
        check("rst_rdata0", bus0.resp_rdata, 32'd0);
        check("rst_err0", 32'(bus0.resp_err), 32'd0);
        check("rst_ready3", 32'(bus3.req_ready), 32'd0);
        rst0 = 1'b0;
        rst3 = 1'b0;
        #1;
        check("ready0_after_rst", 32'(bus0.req_ready), 32'd1);
        check("ready3_after_rst", 32'(bus3.req_ready), 32'd1);

        // Give every byte a known value so random loads are predictable.
        for (int i = 0; i < MEM / 4; i++) issue0(1'b1, 32'(4 * i), 2'b10, 1'b0, $urandom(), rd, er);

        issue0(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, er);
        check("sw_10_rdata", rd, 32'd0);
        check("sw_10_err", 32'(er), 32'd0);
        issue0(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_10", rd, 32'hDEAD_BEEF);
        check("lw_10_err", 32'(er), 32'd0);
        issue0(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, er);
        check("lb_11", rd, 32'hFFFF_FFAD);
        issue0(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, rd, er);
        check("lbu_11", rd, 32'h0000_00AD);
        issue0(1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd, er);
        check("lh_12", rd, 32'hFFFF_BEEF);
        issue0(1'b1, 32'h12, 2'b01, 1'b0, 32'h1234, rd, er);
        issue0(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_10_after_sh", rd, 32'hDEAD_1234);

        issue0(1'b1, 32'h11, 2'b10, 1'b0, 32'hFFFF_FFFF, rd, er);
        check("sw_11_err", 32'(er), 32'd1);
        check("sw_11_rdata", rd, 32'd0);
        issue0(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_10_unchanged", rd, 32'hDEAD_1234);
        issue0(1'b0, 32'h7C, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_7c_err", 32'(er), 32'd0);
        issue0(1'b0, 32'h80, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_80_err", 32'(er), 32'd1);
        check("lw_80_rdata", rd, 32'd0);
        issue0(1'b0, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'h0, rd, er);
        check("lw_fffffffc_err", 32'(er), 32'd1);
        issue0(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, rd, er);
        check("size11_err", 32'(er), 32'd1);
        issue0(1'b0, 32'h7F, 2'b00, 1'b1, 32'h0, rd, er);
        check("lb_7f_err", 32'(er), 32'd0);
        issue0(1'b0, 32'h7F, 2'b01, 1'b0, 32'h0, rd, er);
        check("lh_7f_err", 32'(er), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       addr = $urandom();
                default: addr = 32'($urandom_range(0, MEM + 3));
            endcase
            issue0(1'($urandom()), addr, 2'($urandom()), 1'($urandom()), $urandom(), rd, er);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbQ.size()), 32'd0);

        // Three wait states: exact response cycle, ready profile, capture of inputs.
        issue3(1'b1, 32'h20, 2'b10, 1'b0, 32'hCAFE_F00D, rd, er);
        check("w3_sw_err", 32'(er), 32'd0);
        @(negedge clk);
        budget = 0;
        while (!bus3.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        bus3.req_write = 1'b0;
        bus3.req_addr = 32'h20;
        bus3.req_size = 2'b10;
        bus3.req_unsigned = 1'b0;
        bus3.req_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            vHist[k] = bus3.resp_valid;
            rHist[k] = bus3.req_ready;
            dHist[k] = bus3.resp_rdata;
            eHist[k] = bus3.resp_err;
            if (k == 1) begin
                bus3.req_addr = 32'h44;
                bus3.req_size = 2'b11;
            end
            if (k == 5) begin
                @(posedge clk);
                #1;
                bus3.req_valid = 1'b0;
            end
        end
        for (int k = 1; k <= 9; k++) begin
            check($sformatf("w3_valid_t%0d", k), 32'(vHist[k]), (k == 4 || k == 9) ? 32'd1 : 32'd0);
            check($sformatf("w3_ready_t%0d", k), 32'(rHist[k]), (k == 5) ? 32'd1 : 32'd0);
        end
        check("w3_lw_rdata", dHist[4], 32'hCAFE_F00D);
        check("w3_lw_err", 32'(eHist[4]), 32'd0);
        check("w3_second_err", 32'(eHist[9]), 32'd1);
        check("w3_second_rdata", dHist[9], 32'd0);

        // Reset during the second BUSY cycle drops the pending store.
        issue3(1'b1, 32'h30, 2'b10, 1'b0, 32'h1122_3344, rd, er);
        @(negedge clk);
        bus3.req_write = 1'b1;
        bus3.req_addr = 32'h30;
        bus3.req_size = 2'b10;
        bus3.req_wdata = 32'h5566_7788;
        bus3.req_valid = 1'b1;
        check("w3_rst_ready_pre", 32'(bus3.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus3.req_valid = 1'b0;
        seen = 0;
        @(negedge clk);
        if (bus3.resp_valid) seen++;
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("w3_ready_in_rst", 32'(bus3.req_ready), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) rst3 = 1'b0;
            if (bus3.resp_valid) seen++;
        end
        check("w3_rst_no_resp", 32'(seen), 32'd0);
        issue3(1'b0, 32'h30, 2'b10, 1'b0, 32'h0, rd, er);
        check("w3_rst_mem_kept", rd, 32'h1122_3344);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
